loopback_req_checker: RTL and testbench
=======================================

# loopback_req_checker

Synthesizable, multi-channel read-request checker for the loopback test harness. Each channel replays a programmed table of strided read patterns (base, stride, size, repeat count) and compares every `rd_req` beat against the expected address and size. It sits between the PU memory-interface read-request outputs and the harness status logic, reporting per-channel done/fail, a global pass/fail, and the first mismatch. It supersedes the single-channel behavioural checker with parametrised channel count and table depth, size checking, and sticky error capture.

## Interface
- `NUM_CH`, 4: number of independent read-request channels.
- `ADDR_W`, 32: address width.
- `TX_SIZE_W`, 20: request-size width.
- `RD_LOOP_W`, 10: repeat-count width.
- `CFG_ADDR_W`, 4: log2 pattern-table entries per channel.
- `TIMEOUT`, 100000: watchdog cycles; used only when the watchdog is compiled in.
- Derived: `CH_W = max(1,$clog2(NUM_CH))`; `ENTRY_W = 1+2*ADDR_W+TX_SIZE_W+RD_LOOP_W`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset; asynchronous assertion, active-low.
- `cfg_wr` in 1: table write strobe.
- `cfg_ch` in CH_W: target channel.
- `cfg_idx` in CFG_ADDR_W: target entry.
- `cfg_data` in ENTRY_W: `{last, base, stride, size, loop_max}`, MSB first.
- `ch_en` in NUM_CH: channel enable mask, sampled on `start`.
- `start` in 1: single-cycle run pulse.
- `rd_req` in NUM_CH: per-channel request valid, one beat per cycle.
- `rd_addr` in NUM_CH*ADDR_W: channel c at `[c*ADDR_W +: ADDR_W]`.
- `rd_req_size` in NUM_CH*TX_SIZE_W: request sizes, packed the same way.
- `busy` out NUM_CH: channel in RUN.
- `ch_done` out NUM_CH: channel finished (DONE).
- `ch_fail` out NUM_CH: sticky per-channel error.
- `all_done` out 1: every enabled channel in DONE.
- `pass` out 1: `all_done` and no error.
- `fail` out 1: sticky, any error.
- `err_count` out 16: total errors, saturating at 16'hFFFF.
- `first_err_ch` out CH_W: channel of the first error.
- `first_err_addr` out ADDR_W: offending address of the first error.
- `timeout` out 1: watchdog fired.

## Operation
- Per-channel FSM with states IDLE, RUN, DONE.
  - Reset: IDLE; all counters and flags are 0.
  - `start`: every enabled channel goes to RUN; disabled channels go to DONE.
  - On `start`: entry index = 0, `exp_addr` = entry0.base, `rep_cnt` = 0, and all error state is cleared.
- Table: `NUM_CH * 2^CFG_ADDR_W` entries, asynchronous read, synchronous write.
  - Contents are preserved across `start`.
  - Reset clears the `last` bits only.
  - A `cfg_wr` to a channel in RUN is dropped.
- RUN, on `rd_req[c]`:
  - Error if `rd_addr != exp_addr` or `rd_req_size != entry.size`.
  - If `rep_cnt == loop_max`:
    - If `entry.last`, go to DONE.
    - Otherwise, index+1, `exp_addr` = next base, `rep_cnt` = 0.
  - Otherwise: `exp_addr += stride` (mod 2^ADDR_W) and `rep_cnt += 1`.
  - An entry therefore consumes `loop_max+1` requests.
  - The index wraps mod 2^CFG_ADDR_W if no entry has `last` set.
- `rd_req[c]` in IDLE or DONE is an error (unexpected request); the state is unchanged.
- Error side effects:
  - `ch_fail[c]` and `fail` are set.
  - `err_count` increases by the number of erroring channels that cycle (popcount), saturating.
  - `first_err_*` is captured only while `fail` is 0. On a same-cycle tie the lowest channel index wins.
- `start` while any channel is busy restarts all channels. Error state is cleared and the table is kept.

## Timing
- Checking and all outputs are registered. Effects of a `rd_req` in cycle N are visible in cycle N+1.
- After `start` in cycle N, channels are in RUN at N+1, and a `rd_req` at N+1 is checked against entry 0.
- Zero dead cycles between entries: back-to-back `rd_req` across an entry boundary is checked with no gap.
- `pass`/`all_done` assert in the cycle after the last channel enters DONE.
- Reset values:
  - all outputs 0;
  - `pass` 0, and never 1 before the first `start`.
- `resetn` low mid-run: immediate return to IDLE and all flags cleared.

## Configuration
- `LOOPBACK_CHK_TIMEOUT_EN` defined:
  - A 32-bit idle counter clears on `start` or any `rd_req` and counts while any `busy`.
  - When it reaches `TIMEOUT`, `timeout` and `fail` are set, each busy channel gets `ch_fail` and goes to DONE, and `err_count` += 1.
- Undefined: no counter; `timeout` is tied to 0.

## Test plan
- Ch0 entry {last=1, base=0x1000, stride=0x40, size=16, loop_max=3}, ch_en=4'b0001, 4 matching requests -> `ch_done[0]` and `pass`=1 one cycle after the 4th; `err_count`=0.
- Same setup, 3rd request at 0x1084 -> `fail`=1, `first_err_ch`=0, `first_err_addr`=0x1084, `err_count`=1, channel still completes after the 4th request.
- Two entries (loop_max=0, bases 0x0 and 0x8000, last on entry 1), back-to-back requests -> both accepted; DONE after 2 requests.
- Ch1 and ch2 both mismatch in the same cycle -> `err_count`=2, `first_err_ch`=1.
- `rd_req[3]` while ch3 is disabled/DONE -> `fail`=1, `ch_fail[3]`=1; a new `start` clears it.
- With `LOOPBACK_CHK_TIMEOUT_EN` and `TIMEOUT`=100: start, no requests -> `timeout`=1 at cycle 101, `ch_done`=`ch_fail`=enabled mask.

Source files
------------

// File: rtl/loopback_req_checker.sv
// loopback_req_checker: per-channel replay of strided read-request patterns with sticky error capture.
// The idle watchdog is compiled in only when LOOPBACK_CHK_TIMEOUT_EN is defined.
module loopback_req_checker #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int TX_SIZE_W  = 20,
    parameter int RD_LOOP_W  = 10,
    parameter int CFG_ADDR_W = 4,
    parameter int TIMEOUT    = 100000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ENTRY_W   = 1 + 2*ADDR_W + TX_SIZE_W + RD_LOOP_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cfg_wr,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [CFG_ADDR_W-1:0]       cfg_idx,
    input  logic [ENTRY_W-1:0]          cfg_data,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           rd_req,
    input  logic [NUM_CH*ADDR_W-1:0]    rd_addr,
    input  logic [NUM_CH*TX_SIZE_W-1:0] rd_req_size,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           ch_done,
    output logic [NUM_CH-1:0]           ch_fail,
    output logic                        all_done,
    output logic                        pass,
    output logic                        fail,
    output logic [15:0]                 err_count,
    output logic [CH_W-1:0]             first_err_ch,
    output logic [ADDR_W-1:0]           first_err_addr,
    output logic                        timeout
);

    localparam int DEPTH      = 2**CFG_ADDR_W;
    localparam int TBL_N      = NUM_CH * DEPTH;
    localparam int TA_W       = $clog2(TBL_N);
    localparam int DATA_W     = ENTRY_W - 1;
    localparam int SIZE_LSB   = RD_LOOP_W;
    localparam int STRIDE_LSB = RD_LOOP_W + TX_SIZE_W;
    localparam int BASE_LSB   = STRIDE_LSB + ADDR_W;
    localparam int CNT_W      = CH_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [TA_W-1:0] tbl_addr(input logic [CH_W-1:0] ch,
                                                 input logic [CFG_ADDR_W-1:0] idx);
        return TA_W'(ch) * TA_W'(DEPTH) + TA_W'(idx);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CNT_W-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Lowest set index wins so simultaneous errors report deterministically.
    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = CH_W'(i);
            end
        end
        return r;
    endfunction

    logic [DATA_W-1:0]    tbl_data_q [TBL_N];
    logic [TBL_N-1:0]     tbl_last_q;

    state_e               st_q   [NUM_CH];
    state_e               st_d   [NUM_CH];
    logic [CFG_ADDR_W-1:0] idx_q [NUM_CH];
    logic [CFG_ADDR_W-1:0] idx_d [NUM_CH];
    logic [ADDR_W-1:0]    exp_q  [NUM_CH];
    logic [ADDR_W-1:0]    exp_d  [NUM_CH];
    logic [RD_LOOP_W-1:0] rep_q  [NUM_CH];
    logic [RD_LOOP_W-1:0] rep_d  [NUM_CH];

    logic [NUM_CH-1:0]    ent_last_s;
    logic [ADDR_W-1:0]    ent_stride_s [NUM_CH];
    logic [TX_SIZE_W-1:0] ent_size_s   [NUM_CH];
    logic [RD_LOOP_W-1:0] ent_loop_s   [NUM_CH];
    logic [ADDR_W-1:0]    nxt_base_s   [NUM_CH];
    logic [ADDR_W-1:0]    ent0_base_s  [NUM_CH];
    logic [ADDR_W-1:0]    req_addr_s   [NUM_CH];
    logic [TX_SIZE_W-1:0] req_size_s   [NUM_CH];

    logic [NUM_CH-1:0]    err_s;
    logic                 tmo_fire_s;
    logic                 wr_ok_s;
    logic [TA_W-1:0]      wr_a_s;
    logic [CH_W-1:0]      err_ch_s;
    logic                 all_done_s;

    logic [NUM_CH-1:0]    busy_q, busy_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [NUM_CH-1:0]    ch_fail_q, ch_fail_d;
    logic                 all_done_q;
    logic                 pass_q;
    logic                 fail_q, fail_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [CH_W-1:0]      first_ch_q, first_ch_d;
    logic [ADDR_W-1:0]    first_addr_q, first_addr_d;
    logic                 timeout_q, timeout_d;

    // Per-channel view of the current entry, the following entry and entry 0.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
        logic [TA_W-1:0] cur_a_s;
        logic [TA_W-1:0] nxt_a_s;
        logic [TA_W-1:0] ent0_a_s;
        assign cur_a_s         = tbl_addr(CH_W'(g), idx_q[g]);
        assign nxt_a_s         = tbl_addr(CH_W'(g), idx_q[g] + CFG_ADDR_W'(1));
        assign ent0_a_s        = tbl_addr(CH_W'(g), '0);
        assign ent_last_s[g]   = tbl_last_q[cur_a_s];
        assign ent_stride_s[g] = tbl_data_q[cur_a_s][STRIDE_LSB +: ADDR_W];
        assign ent_size_s[g]   = tbl_data_q[cur_a_s][SIZE_LSB +: TX_SIZE_W];
        assign ent_loop_s[g]   = tbl_data_q[cur_a_s][0 +: RD_LOOP_W];
        assign nxt_base_s[g]   = tbl_data_q[nxt_a_s][BASE_LSB +: ADDR_W];
        assign ent0_base_s[g]  = tbl_data_q[ent0_a_s][BASE_LSB +: ADDR_W];
        assign req_addr_s[g]   = rd_addr[g*ADDR_W +: ADDR_W];
        assign req_size_s[g]   = rd_req_size[g*TX_SIZE_W +: TX_SIZE_W];
    end

    assign wr_a_s = tbl_addr(cfg_ch, cfg_idx);

    // Table writes are refused while the addressed channel is replaying.
    always_comb begin
        wr_ok_s = 1'b0;
        if (cfg_wr && (int'(cfg_ch) < NUM_CH)) begin
            wr_ok_s = (st_q[cfg_ch] != ST_RUN);
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Pattern payload has no reset so the table survives start and reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            tbl_data_q[wr_a_s] <= cfg_data[DATA_W-1:0];
        end
    end

    // Last flags are cleared by reset so stale entries cannot end a run early.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tbl_last_q <= '0;
        end else if (wr_ok_s) begin
            tbl_last_q[wr_a_s] <= cfg_data[ENTRY_W-1];
        end
    end

`ifdef LOOPBACK_CHK_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        any_busy_s;

    assign any_busy_s = |busy_q;

    // Watchdog: counts cycles with a channel running and no request seen.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        tmo_fire_s = 1'b0;
        if (start || (|rd_req)) begin
            idle_cnt_d = 32'd0;
        end else if (any_busy_s) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
            tmo_fire_s = (idle_cnt_d == 32'(TIMEOUT));
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic [31:0] tmo_unused_s;
    assign tmo_unused_s = 32'(TIMEOUT);
    assign tmo_fire_s   = 1'b0;
`endif

    assign err_ch_s = lowest_idx(err_s);

    // Channel FSMs, request checking and error bookkeeping.
    always_comb begin
        st_d         = st_q;
        idx_d        = idx_q;
        exp_d        = exp_q;
        rep_d        = rep_q;
        err_s        = '0;
        ch_fail_d    = ch_fail_q;
        fail_d       = fail_q;
        err_cnt_d    = err_cnt_q;
        first_ch_d   = first_ch_q;
        first_addr_d = first_addr_q;
        timeout_d    = timeout_q;
        if (start) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_d[c]  = ch_en[c] ? ST_RUN : ST_DONE;
                idx_d[c] = '0;
                exp_d[c] = ent0_base_s[c];
                rep_d[c] = '0;
            end
            ch_fail_d    = '0;
            fail_d       = 1'b0;
            err_cnt_d    = 16'd0;
            first_ch_d   = '0;
            first_addr_d = '0;
            timeout_d    = 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_req[c] && (st_q[c] == ST_RUN)) begin
                    err_s[c] = (req_addr_s[c] != exp_q[c]) || (req_size_s[c] != ent_size_s[c]);
                    if (rep_q[c] == ent_loop_s[c]) begin
                        if (ent_last_s[c]) begin
                            st_d[c] = ST_DONE;
                        end else begin
                            idx_d[c] = idx_q[c] + CFG_ADDR_W'(1);
                            exp_d[c] = nxt_base_s[c];
                            rep_d[c] = '0;
                        end
                    end else begin
                        exp_d[c] = exp_q[c] + ent_stride_s[c];
                        rep_d[c] = rep_q[c] + RD_LOOP_W'(1);
                    end
                end else if (rd_req[c]) begin
                    err_s[c] = 1'b1;
                end else if (tmo_fire_s && (st_q[c] == ST_RUN)) begin
                    st_d[c]      = ST_DONE;
                    ch_fail_d[c] = 1'b1;
                end else begin
                    st_d[c] = st_q[c];
                end
            end
            if ((|err_s) && !fail_q) begin
                first_ch_d   = err_ch_s;
                first_addr_d = req_addr_s[err_ch_s];
            end else begin
                first_ch_d   = first_ch_q;
                first_addr_d = first_addr_q;
            end
            ch_fail_d = ch_fail_d | err_s;
            fail_d    = fail_q | (|err_s) | tmo_fire_s;
            timeout_d = timeout_q | tmo_fire_s;
            err_cnt_d = sat_add(err_cnt_q, popcount(err_s) + CNT_W'(tmo_fire_s));
        end
    end

    // Status decode of the next state, registered below.
    always_comb begin
        busy_d = '0;
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_d[c] = (st_d[c] == ST_RUN);
            done_d[c] = (st_d[c] == ST_DONE);
        end
        all_done_s = &done_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= ST_IDLE;
                idx_q[c] <= '0;
                exp_q[c] <= '0;
                rep_q[c] <= '0;
            end
            busy_q       <= '0;
            done_q       <= '0;
            ch_fail_q    <= '0;
            all_done_q   <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_cnt_q    <= 16'd0;
            first_ch_q   <= '0;
            first_addr_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= st_d[c];
                idx_q[c] <= idx_d[c];
                exp_q[c] <= exp_d[c];
                rep_q[c] <= rep_d[c];
            end
            busy_q       <= busy_d;
            done_q       <= done_d;
            ch_fail_q    <= ch_fail_d;
            all_done_q   <= all_done_s;
            pass_q       <= all_done_s & ~fail_d;
            fail_q       <= fail_d;
            err_cnt_q    <= err_cnt_d;
            first_ch_q   <= first_ch_d;
            first_addr_q <= first_addr_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy           = busy_q;
    assign ch_done        = done_q;
    assign ch_fail        = ch_fail_q;
    assign all_done       = all_done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_count      = err_cnt_q;
    assign first_err_ch   = first_ch_q;
    assign first_err_addr = first_addr_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_loopback_req_checker.sv
// Directed bench for loopback_req_checker; also covers the watchdog when LOOPBACK_CHK_TIMEOUT_EN is set.
module tb_loopback_req_checker;

    localparam int NUM_CH     = 4;
    localparam int ADDR_W     = 32;
    localparam int TX_SIZE_W  = 20;
    localparam int RD_LOOP_W  = 10;
    localparam int CFG_ADDR_W = 4;
    localparam int CH_W       = 2;
    localparam int ENTRY_W    = 1 + 2*ADDR_W + TX_SIZE_W + RD_LOOP_W;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        cfg_wr;
    logic [CH_W-1:0]             cfg_ch;
    logic [CFG_ADDR_W-1:0]       cfg_idx;
    logic [ENTRY_W-1:0]          cfg_data;
    logic [NUM_CH-1:0]           ch_en;
    logic                        start;
    logic [NUM_CH-1:0]           rd_req;
    logic [NUM_CH*ADDR_W-1:0]    rd_addr;
    logic [NUM_CH*TX_SIZE_W-1:0] rd_req_size;
    logic [NUM_CH-1:0]           busy;
    logic [NUM_CH-1:0]           ch_done;
    logic [NUM_CH-1:0]           ch_fail;
    logic                        all_done;
    logic                        pass;
    logic                        fail;
    logic [15:0]                 err_count;
    logic [CH_W-1:0]             first_err_ch;
    logic [ADDR_W-1:0]           first_err_addr;
    logic                        timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    loopback_req_checker #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TX_SIZE_W(TX_SIZE_W),
        .RD_LOOP_W(RD_LOOP_W), .CFG_ADDR_W(CFG_ADDR_W), .TIMEOUT(100)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .ch_en(ch_en), .start(start), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_req_size(rd_req_size), .busy(busy), .ch_done(ch_done),
        .ch_fail(ch_fail), .all_done(all_done), .pass(pass), .fail(fail),
        .err_count(err_count), .first_err_ch(first_err_ch),
        .first_err_addr(first_err_addr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int idx, input logic last,
                             input logic [31:0] base, input logic [31:0] stride,
                             input logic [19:0] size, input logic [9:0] loopm);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_idx  = CFG_ADDR_W'(idx);
        cfg_data = {last, base, stride, size, loopm};
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] mask);
        ch_en = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic req1(input int ch, input logic [31:0] a, input logic [19:0] s);
        rd_req = '0;
        rd_req[ch] = 1'b1;
        rd_addr[ch*ADDR_W +: ADDR_W] = a;
        rd_req_size[ch*TX_SIZE_W +: TX_SIZE_W] = s;
        tick();
        rd_req = '0;
    endtask

    initial begin
        resetn = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_idx = '0; cfg_data = '0;
        ch_en = '0; start = 1'b0; rd_req = '0; rd_addr = '0; rd_req_size = '0;
        tick(); tick();
        chk("rst_busy", busy, 4'b0000);
        chk("rst_done", ch_done, 4'b0000);
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_errcnt", err_count, 16'd0);
        chk("rst_timeout", timeout, 1'b0);
        resetn = 1'b1;
        tick();

        // Stray request while IDLE
        req1(2, 32'h77, 20'd0);
        chk("idle_req_fail", fail, 1'b1);
        chk("idle_req_chfail", ch_fail, 4'b0100);
        chk("idle_req_errch", first_err_ch, 2'd2);
        chk("idle_req_state", ch_done, 4'b0000);
        chk("idle_req_pass", pass, 1'b0);

        // Single entry, four matching requests
        cfg_write(0, 0, 1'b1, 32'h1000, 32'h40, 20'd16, 10'd3);
        do_start(4'b0001);
        chk("t1_busy", busy, 4'b0001);
        chk("t1_done_dis", ch_done, 4'b1110);
        chk("t1_fail_clr", fail, 1'b0);
        req1(0, 32'h1000, 20'd16);
        req1(0, 32'h1040, 20'd16);
        req1(0, 32'h1080, 20'd16);
        chk("t1_pass_early", pass, 1'b0);
        req1(0, 32'h10C0, 20'd16);
        chk("t1_done", ch_done, 4'b1111);
        chk("t1_pass", pass, 1'b1);
        chk("t1_alldone", all_done, 1'b1);
        chk("t1_errcnt", err_count, 16'd0);

        // Same setup, third request off by 4
        do_start(4'b0001);
        req1(0, 32'h1000, 20'd16);
        req1(0, 32'h1040, 20'd16);
        req1(0, 32'h1084, 20'd16);
        chk("t2_fail", fail, 1'b1);
        chk("t2_errch", first_err_ch, 2'd0);
        chk("t2_erraddr", first_err_addr, 32'h1084);
        chk("t2_errcnt", err_count, 16'd1);
        chk("t2_busy", busy, 4'b0001);
        req1(0, 32'h10C0, 20'd16);
        chk("t2_done", ch_done, 4'b1111);
        chk("t2_pass", pass, 1'b0);
        chk("t2_errcnt_end", err_count, 16'd1);

        // Two single-beat entries, back to back
        cfg_write(0, 0, 1'b0, 32'h0, 32'h0, 20'd8, 10'd0);
        cfg_write(0, 1, 1'b1, 32'h8000, 32'h0, 20'd8, 10'd0);
        do_start(4'b0001);
        req1(0, 32'h0, 20'd8);
        chk("t3_mid_busy", busy, 4'b0001);
        req1(0, 32'h8000, 20'd8);
        chk("t3_done", ch_done, 4'b1111);
        chk("t3_pass", pass, 1'b1);

        // Ch1 address and ch2 size mismatch in the same cycle
        cfg_write(1, 0, 1'b1, 32'h2000, 32'h4, 20'd4, 10'd1);
        cfg_write(2, 0, 1'b1, 32'h3000, 32'h4, 20'd4, 10'd1);
        do_start(4'b0110);
        chk("t4_done_dis", ch_done, 4'b1001);
        rd_req = 4'b0110;
        rd_addr[1*ADDR_W +: ADDR_W] = 32'h2001; rd_req_size[1*TX_SIZE_W +: TX_SIZE_W] = 20'd4;
        rd_addr[2*ADDR_W +: ADDR_W] = 32'h3000; rd_req_size[2*TX_SIZE_W +: TX_SIZE_W] = 20'd5;
        tick();
        rd_req = '0;
        chk("t4_errcnt", err_count, 16'd2);
        chk("t4_errch", first_err_ch, 2'd1);
        chk("t4_erraddr", first_err_addr, 32'h2001);
        chk("t4_chfail", ch_fail, 4'b0110);
        rd_req = 4'b0110;
        rd_addr[1*ADDR_W +: ADDR_W] = 32'h2004;
        rd_addr[2*ADDR_W +: ADDR_W] = 32'h3004; rd_req_size[2*TX_SIZE_W +: TX_SIZE_W] = 20'd4;
        tick();
        rd_req = '0;
        chk("t4_done", ch_done, 4'b1111);
        chk("t4_pass", pass, 1'b0);
        chk("t4_errcnt_end", err_count, 16'd2);

        // Request on a disabled channel, then restart clears it
        do_start(4'b0001);
        chk("t5_clr_fail", fail, 1'b0);
        chk("t5_clr_cnt", err_count, 16'd0);
        req1(3, 32'h55, 20'd1);
        chk("t5_fail", fail, 1'b1);
        chk("t5_chfail", ch_fail, 4'b1000);
        chk("t5_erraddr", first_err_addr, 32'h55);
        chk("t5_state", ch_done, 4'b1110);
        do_start(4'b0001);
        chk("t5_restart_fail", fail, 1'b0);
        chk("t5_restart_chfail", ch_fail, 4'b0000);

        // Table write to a running channel is dropped
        cfg_write(0, 1, 1'b1, 32'hBAD0, 32'h0, 20'd8, 10'd0);
        req1(0, 32'h0, 20'd8);
        req1(0, 32'h8000, 20'd8);
        chk("t6_pass", pass, 1'b1);
        chk("t6_errcnt", err_count, 16'd0);

        // Address wraps modulo 2^32
        cfg_write(0, 0, 1'b1, 32'hFFFF_FFF0, 32'h20, 20'd1, 10'd1);
        do_start(4'b0001);
        req1(0, 32'hFFFF_FFF0, 20'd1);
        req1(0, 32'h0000_0010, 20'd1);
        chk("t7_pass", pass, 1'b1);

        // Reset mid-run returns to IDLE at once
        do_start(4'b0001);
        req1(0, 32'hFFFF_FFF0, 20'd1);
        resetn = 1'b0;
        #1;
        chk("t8_busy", busy, 4'b0000);
        chk("t8_done", ch_done, 4'b0000);
        tick();
        resetn = 1'b1;
        tick();

`ifdef LOOPBACK_CHK_TIMEOUT_EN
        do_start(4'b1111);
        repeat (99) tick();
        chk("tmo_early", timeout, 1'b0);
        tick();
        chk("tmo_fire", timeout, 1'b1);
        chk("tmo_done", ch_done, 4'b1111);
        chk("tmo_chfail", ch_fail, 4'b1111);
        chk("tmo_errcnt", err_count, 16'd1);
`else
        do_start(4'b1111);
        repeat (120) tick();
        chk("tmo_off", timeout, 1'b0);
        chk("tmo_off_busy", busy, 4'b1111);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
